// File: rtl/spi_slave.sv
// SPI slave (CPOL=1, MSB first) bridging opcode/address/data frames onto a simple
// register-file port. All SPI pins are oversampled in the clk domain.
module spi_slave #(
  parameter logic [7:0] WR_OP = 8'h3C,
  parameter logic [7:0] RD_OP = 8'h5B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scsn,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {IDLE, OP, ADDR, WDATA, RDATA, DISCARD} state_t;

  logic       scsn_m_r, scsn_s_r, scsn_d_r;
  logic       sclk_m_r, sclk_s_r, sclk_d_r;
  logic       mosi_m_r, mosi_s_r;
  logic [1:0] flush_r;
  logic       armed_r;
  state_t     state_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] rx_r;
  logic [7:0] addr_r;
  logic [7:0] tx_r;
  logic       op_rd_r;
  logic       rd_pend_r;
  logic       wr_en_r, rd_req_r, busy_r, frame_err_r;
  logic [7:0] wr_addr_r, wr_data_r, rd_addr_r;

  logic       sclk_rise_s;
  logic       scsn_fall_s;
  logic       byte_done_s;
  logic [7:0] byte_s;

  assign sclk_rise_s = sclk_s_r & ~sclk_d_r;
  assign scsn_fall_s = ~scsn_s_r & scsn_d_r;
  assign byte_s      = {rx_r, mosi_s_r};
  assign byte_done_s = sclk_rise_s && (bit_cnt_r == 3'd7);

  assign miso      = tx_r[7];
  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign rd_req    = rd_req_r;
  assign rd_addr   = rd_addr_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;

  // Two-flop synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scsn_m_r <= 1'b1; scsn_s_r <= 1'b1; scsn_d_r <= 1'b1;
      sclk_m_r <= 1'b1; sclk_s_r <= 1'b1; sclk_d_r <= 1'b1;
      mosi_m_r <= 1'b1; mosi_s_r <= 1'b1;
    end else begin
      scsn_m_r <= scsn; scsn_s_r <= scsn_m_r; scsn_d_r <= scsn_s_r;
      sclk_m_r <= sclk; sclk_s_r <= sclk_m_r; sclk_d_r <= sclk_s_r;
      mosi_m_r <= mosi; mosi_s_r <= mosi_m_r;
    end
  end

  // Frame FSM, shift registers and register-file strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'd0;
      rx_r        <= 7'd0;
      addr_r      <= 8'h00;
      tx_r        <= 8'hFF;
      op_rd_r     <= 1'b0;
      rd_pend_r   <= 1'b0;
      flush_r     <= 2'd2;
      armed_r     <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= 8'h00;
      wr_data_r   <= 8'h00;
      rd_req_r    <= 1'b0;
      rd_addr_r   <= 8'h00;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      wr_en_r     <= 1'b0;
      rd_req_r    <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= ~scsn_s_r;
      rd_pend_r   <= rd_req_r;
      // Until the synchronizers hold real pin values and scsn is seen high, a frame
      // already in flight at reset release must not be mistaken for a new select.
      if (flush_r != 2'd0) begin
        flush_r <= flush_r - 2'd1;
      end else if (scsn_s_r) begin
        armed_r <= 1'b1;
      end
      if ((state_r != IDLE) && scsn_s_r) begin
        frame_err_r <= (bit_cnt_r != 3'd0) || (state_r == OP) ||
                       (state_r == ADDR) || (state_r == DISCARD);
        state_r     <= IDLE;
        bit_cnt_r   <= 3'd0;
        tx_r        <= 8'hFF;
      end else if (state_r == IDLE) begin
        tx_r <= 8'hFF;
        if (scsn_fall_s && armed_r) begin
          state_r   <= OP;
          bit_cnt_r <= 3'd0;
        end
      end else if (sclk_rise_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        rx_r      <= byte_s[6:0];
        case (state_r)
          OP: begin
            if (byte_done_s) begin
              if (byte_s == WR_OP) begin
                state_r <= ADDR;
                op_rd_r <= 1'b0;
              end else if (byte_s == RD_OP) begin
                state_r <= ADDR;
                op_rd_r <= 1'b1;
              end else begin
                state_r <= DISCARD;
              end
            end
          end
          ADDR: begin
            if (byte_done_s) begin
              if (op_rd_r) begin
                state_r   <= RDATA;
                rd_req_r  <= 1'b1;
                rd_addr_r <= byte_s;
                addr_r    <= byte_s + 8'd1;
              end else begin
                state_r <= WDATA;
                addr_r  <= byte_s;
              end
            end
          end
          WDATA: begin
            if (byte_done_s) begin
              wr_en_r   <= 1'b1;
              wr_addr_r <= addr_r;
              wr_data_r <= byte_s;
              addr_r    <= addr_r + 8'd1;
            end
          end
          RDATA: begin
            if (byte_done_s) begin
              rd_req_r  <= 1'b1;
              rd_addr_r <= addr_r;
              addr_r    <= addr_r + 8'd1;
            end else begin
              tx_r <= {tx_r[6:0], 1'b1};
            end
          end
          default: begin
          end
        endcase
      end else if ((state_r == RDATA) && rd_pend_r) begin
        tx_r <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged SPI master, register-file model and
// event logs of the write/read strobes and frame errors.
module tb_spi_slave;
  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scsn = 1'b1;
  logic       sclk = 1'b1;
  logic       mosi = 1'b1;
  logic       miso;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic       busy;
  logic       frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int err_n    = 0;
  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  logic [7:0]  mem[256];
  logic [7:0]  rx_buf[8];

  spi_slave dut (
    .clk(clk), .rst(rst), .scsn(scsn), .sclk(sclk), .mosi(mosi), .miso(miso),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register file: data valid one clk after the request.
  always @(posedge clk) begin
    if (rd_req) rd_data <= mem[rd_addr];
  end

  // Event logs sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_en) wr_log.push_back({wr_addr, wr_data});
    if (rd_req) rd_log.push_back(rd_addr);
    if (frame_err) err_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [16:0] wr_at(input int i);
    if (i < wr_log.size()) return {1'b1, wr_log[i]};
    return 17'h0;
  endfunction

  function automatic logic [8:0] rd_at(input int i);
    if (i < rd_log.size()) return {1'b1, rd_log[i]};
    return 9'h0;
  endfunction

  // Master: drive mosi and sample miso at each falling edge; slave samples on rising.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'hFF;
    for (int i = 7; i >= 8 - n; i--) begin
      sclk = 1'b0;
      rx[i] = miso;
      mosi = tx[i];
      #HALF;
      sclk = 1'b1;
      #HALF;
    end
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input int n, input int partial);
    logic [7:0] bytes[4];
    logic [7:0] r;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    scsn = 1'b0;
    #100;
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int b = 0; b < n; b++) begin
      spi_bits(bytes[b], 8, r);
      rx_buf[b] = r;
    end
    if (partial > 0) spi_bits(bytes[n], partial, r);
    #100;
    scsn = 1'b1;
    #200;
  endtask

  initial begin
    int wb, rb, eb;
    logic [7:0] r;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'hC3;
    mem[8'h21] = 8'h3C;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_miso", 32'(miso), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    #100;

    // Write frame 3C,10,AA,55
    wb = wr_log.size(); rb = rd_log.size(); eb = err_n;
    run_frame(8'h3C, 8'h10, 8'hAA, 8'h55, 4, 0);
    check("wr_cnt", 32'(wr_log.size() - wb), 32'd2);
    check("wr0", 32'(wr_at(wb)), 32'h1_10AA);
    check("wr1", 32'(wr_at(wb + 1)), 32'h1_1155);
    check("wr_no_rd", 32'(rd_log.size() - rb), 32'd0);
    check("wr_no_err", 32'(err_n - eb), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);

    // Read frame 5B,20 + 2 bytes
    wb = wr_log.size(); rb = rd_log.size(); eb = err_n;
    run_frame(8'h5B, 8'h20, 8'h00, 8'h00, 4, 0);
    check("rd_miso_op", 32'(rx_buf[0]), 32'hFF);
    check("rd_miso_addr", 32'(rx_buf[1]), 32'hFF);
    check("rd_data0", 32'(rx_buf[2]), 32'hC3);
    check("rd_data1", 32'(rx_buf[3]), 32'h3C);
    check("rd_cnt", 32'(rd_log.size() - rb), 32'd3);
    check("rd_a0", 32'(rd_at(rb)), 32'h120);
    check("rd_a1", 32'(rd_at(rb + 1)), 32'h121);
    check("rd_a2", 32'(rd_at(rb + 2)), 32'h122);
    check("rd_no_wr", 32'(wr_log.size() - wb), 32'd0);
    check("rd_no_err", 32'(err_n - eb), 32'd0);

    // Write with address wrap
    wb = wr_log.size(); eb = err_n;
    run_frame(8'h3C, 8'hFF, 8'h01, 8'h02, 4, 0);
    check("wrap_cnt", 32'(wr_log.size() - wb), 32'd2);
    check("wrap0", 32'(wr_at(wb)), 32'h1_FF01);
    check("wrap1", 32'(wr_at(wb + 1)), 32'h1_0002);
    check("wrap_no_err", 32'(err_n - eb), 32'd0);

    // Unknown opcode
    wb = wr_log.size(); rb = rd_log.size(); eb = err_n;
    run_frame(8'h77, 8'h5B, 8'h3C, 8'h12, 4, 0);
    check("bad_no_wr", 32'(wr_log.size() - wb), 32'd0);
    check("bad_no_rd", 32'(rd_log.size() - rb), 32'd0);
    check("bad_miso", 32'({rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3]}), 32'hFFFF_FFFF);
    check("bad_err", 32'(err_n - eb), 32'd1);

    // Partial data byte, then a good frame
    wb = wr_log.size(); eb = err_n;
    run_frame(8'h3C, 8'h40, 8'hA0, 8'h00, 2, 5);
    check("part_no_wr", 32'(wr_log.size() - wb), 32'd0);
    check("part_err", 32'(err_n - eb), 32'd1);
    wb = wr_log.size(); eb = err_n;
    run_frame(8'h3C, 8'h41, 8'h99, 8'h00, 3, 0);
    check("after_part_cnt", 32'(wr_log.size() - wb), 32'd1);
    check("after_part_wr", 32'(wr_at(wb)), 32'h1_4199);
    check("after_part_err", 32'(err_n - eb), 32'd0);

    // Reset during the address byte of a write frame
    wb = wr_log.size(); rb = rd_log.size(); eb = err_n;
    scsn = 1'b0;
    #100;
    spi_bits(8'h3C, 8, r);
    spi_bits(8'h05, 4, r);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_miso", 32'(miso), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
    check("mid_rst_strobes", 32'({wr_en, rd_req, frame_err}), 32'd0);
    rst = 1'b0;
    spi_bits(8'h05, 4, r);
    spi_bits(8'hEE, 8, r);
    #100;
    scsn = 1'b1;
    #200;
    check("mid_rst_no_wr", 32'(wr_log.size() - wb), 32'd0);
    check("mid_rst_no_rd", 32'(rd_log.size() - rb), 32'd0);
    check("mid_rst_no_err", 32'(err_n - eb), 32'd0);
    wb = wr_log.size();
    run_frame(8'h3C, 8'h05, 8'h0F, 8'h00, 3, 0);
    check("post_rst_cnt", 32'(wr_log.size() - wb), 32'd1);
    check("post_rst_wr", 32'(wr_at(wb)), 32'h1_050F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
